// File: rtl/four_mag_pkg.sv
// Shared constants and the FIFO word layout for the 4-channel magnitude collector.
package four_mag_pkg;
  localparam int NCHAN  = 4;
  localparam int CHAN_W = 2;
  localparam int MAG_W  = 26;
  localparam int USER_W = 4;

  // Word layout is {ovf, user, mag3..mag0}, chan0 magnitude in the LSBs.
  typedef struct packed {
    logic [NCHAN-1:0]            ovf;
    logic [USER_W-1:0]           user;
    logic [NCHAN-1:0][MAG_W-1:0] mag;
  } mag_word_t;
endpackage

// File: rtl/mag_word_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees room for a same-cycle push.
module mag_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
endmodule

// File: rtl/four_mag_collect.sv
// Assembles per-channel magnitude beats into 4-channel words and queues them.
// Optional sequence checking is enabled with the MAG_SEQ_CHECK_EN macro.
module four_mag_collect
  import four_mag_pkg::*;
#(
  parameter int IO_WIDTH       = 26,
  parameter int S_TUSER_WIDTH  = 4,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IO_WIDTH-1:0]        S_TDATA,
  input  logic [S_TUSER_WIDTH+1:0]   S_TUSER,
  input  logic                       S_TVALID,
  input  logic                       S_OVERFLOW,
  output logic [4*IO_WIDTH-1:0]      M_TDATA,
  output logic [S_TUSER_WIDTH-1:0]   M_TUSER,
  output logic [3:0]                 M_TOVERFLOW,
  output logic                       M_TVALID,
  input  logic                       M_TREADY,
  output logic [15:0]                dropCount,
  output logic                       seqError
);
  localparam int WORD_W = NCHAN + S_TUSER_WIDTH + NCHAN*IO_WIDTH;

  logic [CHAN_W-1:0]         chan;
  logic [S_TUSER_WIDTH-1:0]  user;
  logic [S_TUSER_WIDTH-1:0]  frame_user;
  logic [IO_WIDTH-1:0]       slot_reg [NCHAN-1];
  logic [NCHAN-2:0]          ovf_reg;
  logic [NCHAN*IO_WIDTH-1:0] frame_mag;
  logic                      seq_viol;
  logic                      complete;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [WORD_W-1:0]         wr_word;
  logic [WORD_W-1:0]         rd_word;
  logic [15:0]               drop_count_reg;

  assign chan = S_TUSER[CHAN_W-1:0];
  assign user = S_TUSER[S_TUSER_WIDTH+CHAN_W-1:CHAN_W];

`ifdef MAG_SEQ_CHECK_EN
  logic [CHAN_W-1:0]        exp_chan_reg;
  logic [S_TUSER_WIDTH-1:0] user0_reg;
  logic                     seq_error_reg;

  assign seq_viol = S_TVALID &&
                    ((chan != exp_chan_reg) || (chan != '0 && user != user0_reg));

  // A violating chan0 beat restarts the frame, so expected becomes chan+1 either way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_chan_reg  <= '0;
      user0_reg     <= '0;
      seq_error_reg <= 1'b0;
    end else begin
      seq_error_reg <= seq_viol;
      if (S_TVALID) begin
        if (chan == '0) user0_reg <= user;
        exp_chan_reg <= (seq_viol && chan != '0) ? '0 : chan + CHAN_W'(1);
      end
    end
  end

  assign frame_user = user0_reg;
  assign seqError   = seq_error_reg;
`else
  assign seq_viol   = 1'b0;
  assign frame_user = user;
  assign seqError   = 1'b0;
`endif

  assign complete = S_TVALID && !seq_viol && (chan == CHAN_W'(NCHAN-1));

  // The last channel is never stored: it goes straight into the pushed word.
  for (genvar gi = 0; gi < NCHAN-1; gi++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_reg[gi] <= '0;
        ovf_reg[gi]  <= 1'b0;
      end else if (S_TVALID) begin
        if (chan == CHAN_W'(gi)) begin
          slot_reg[gi] <= S_TDATA;
          ovf_reg[gi]  <= S_OVERFLOW && (gi == 0 || !seq_viol);
        end else if (complete || seq_viol) begin
          ovf_reg[gi]  <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_mag
    if (gi == NCHAN-1) begin : g_last
      assign frame_mag[gi*IO_WIDTH +: IO_WIDTH] = S_TDATA;
    end else begin : g_stored
      assign frame_mag[gi*IO_WIDTH +: IO_WIDTH] = slot_reg[gi];
    end
  end

  assign wr_word = {S_OVERFLOW, ovf_reg, frame_user, frame_mag};

  mag_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (complete),
    .wr_data (wr_word),
    .pop     (M_TREADY),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_reg <= '0;
    end else if (complete && fifo_full && !M_TREADY && drop_count_reg != 16'hFFFF) begin
      drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign M_TVALID    = !fifo_empty;
  assign M_TDATA     = rd_word[NCHAN*IO_WIDTH-1:0];
  assign M_TUSER     = rd_word[NCHAN*IO_WIDTH +: S_TUSER_WIDTH];
  assign M_TOVERFLOW = rd_word[WORD_W-1 -: NCHAN];
  assign dropCount   = drop_count_reg;
endmodule
